// File: rtl/fact_dp_pkg.sv
// Shared constants and types for the factorial datapath and its controller.
package fact_pkg;

  localparam int FACT_WIDTH   = 32;
  localparam int FACT_N_WIDTH = 4;
  localparam int unsigned FACT_ONE = 32'd1;

  typedef enum logic {
    SRC_MUL = 1'b0,
    SRC_ONE = 1'b1
  } prod_src_e;

endpackage

// File: rtl/fact_dp_if.sv
// Control/status bundle between the factorial controller (master) and datapath (slave).
interface fact_dp_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4
);
  logic [N_WIDTH-1:0] N;
  logic               MUX;
  logic               REG_LD;
  logic               CNT_LD;
  logic               CNT_EN;
  logic               DONE;
  logic               GT;
  logic [WIDTH-1:0]   PRODUCT;
  logic [WIDTH-1:0]   RESULT;
  logic               RESULT_VALID;
  logic               OVF;

  modport master (
    output N, MUX, REG_LD, CNT_LD, CNT_EN, DONE,
    input  GT, PRODUCT, RESULT, RESULT_VALID, OVF
  );

  modport slave (
    input  N, MUX, REG_LD, CNT_LD, CNT_EN, DONE,
    output GT, PRODUCT, RESULT, RESULT_VALID, OVF
  );
endinterface

// File: rtl/fact_dp_cnt.sv
// Loop counter: loads 1, counts up while enabled, freezes once the compare flag is set.
module fact_cnt
  import fact_pkg::*;
#(
  parameter int N_WIDTH = FACT_N_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic             gt,
  output logic [N_WIDTH:0] cnt
);

  logic [N_WIDTH:0] cnt_r;

  // Counter register, load has priority over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (ld) begin
      cnt_r <= (N_WIDTH+1)'(FACT_ONE);
    end else if (en && !gt) begin
      cnt_r <= cnt_r + {{N_WIDTH{1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/fact_dp.sv
// Iterative factorial datapath: product register, loop compare, result capture.
// Optional sticky overflow detection is built when FACT_DP_OVF_EN is defined.
module fact_dp
  import fact_pkg::*;
#(
  parameter int WIDTH   = FACT_WIDTH,
  parameter int N_WIDTH = FACT_N_WIDTH
) (
  input  logic       CLK,
  input  logic       RST,
  fact_dp_if.slave   bus
);

  logic [N_WIDTH-1:0] n_reg_r;
  logic [N_WIDTH:0]   cnt_s;
  logic               gt_s;
  logic [WIDTH-1:0]   product_r;
  logic [WIDTH-1:0]   prod_nxt_s;
  logic [WIDTH-1:0]   mul_lo_s;
  logic               mul_upd_s;
  logic [WIDTH-1:0]   result_r;
  logic               result_valid_r;
  logic               done_q_r;

  fact_cnt #(.N_WIDTH(N_WIDTH)) u_cnt (
    .clk (CLK),
    .rst (RST),
    .ld  (bus.CNT_LD),
    .en  (bus.CNT_EN),
    .gt  (gt_s),
    .cnt (cnt_s)
  );

  assign gt_s = (cnt_s > {1'b0, n_reg_r});

`ifdef FACT_DP_OVF_EN
  logic [WIDTH+N_WIDTH:0] mul_full_s;
  logic                   ovf_r;

  assign mul_full_s = {{(N_WIDTH+1){1'b0}}, product_r} * {{WIDTH{1'b0}}, cnt_s};
  assign mul_lo_s   = mul_full_s[WIDTH-1:0];

  // Sticky overflow, cleared by a new operand load
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_r <= 1'b0;
    end else if (bus.CNT_LD) begin
      ovf_r <= 1'b0;
    end else if (mul_upd_s && (|mul_full_s[WIDTH+N_WIDTH:WIDTH])) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.OVF = ovf_r;
`else
  assign mul_lo_s = product_r * {{(WIDTH-N_WIDTH-1){1'b0}}, cnt_s};
  assign bus.OVF  = 1'b0;
`endif

  // Next product; multiply is blocked once GT so the product stops at N!
  always_comb begin
    prod_nxt_s = product_r;
    mul_upd_s  = 1'b0;
    case (prod_src_e'(bus.MUX))
      SRC_ONE: begin
        if (bus.REG_LD) begin
          prod_nxt_s = WIDTH'(FACT_ONE);
        end else begin
          prod_nxt_s = product_r;
        end
      end
      SRC_MUL: begin
        if (bus.REG_LD && !gt_s) begin
          prod_nxt_s = mul_lo_s;
          mul_upd_s  = 1'b1;
        end else begin
          prod_nxt_s = product_r;
        end
      end
      default: prod_nxt_s = product_r;
    endcase
  end

  // Operand latch and product register
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_reg_r   <= '0;
      product_r <= '0;
    end else begin
      n_reg_r   <= bus.CNT_LD ? bus.N : n_reg_r;
      product_r <= prod_nxt_s;
    end
  end

  // Result capture on the rising edge of DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q_r       <= 1'b0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
    end else begin
      done_q_r <= bus.DONE;
      if (bus.DONE && !done_q_r) begin
        result_r       <= product_r;
        result_valid_r <= 1'b1;
      end else begin
        result_r       <= result_r;
        result_valid_r <= 1'b0;
      end
    end
  end

  assign bus.GT           = gt_s;
  assign bus.PRODUCT      = product_r;
  assign bus.RESULT       = result_r;
  assign bus.RESULT_VALID = result_valid_r;

endmodule

// File: tb/tb_fact_dp.sv
// Self-checking bench for fact_dp acting as the controller; factorial reference model.
module tb_fact_dp;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fact_dp_if #(.WIDTH(32), .N_WIDTH(4)) bus ();

  fact_dp #(.WIDTH(32), .N_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: n! evaluated with 32-bit truncation at every step
  function automatic void ref_fact(input int n, output logic [31:0] res, output logic ovf);
    longint unsigned p = 1;
    longint unsigned full;
    ovf = 1'b0;
    for (int k = 1; k <= n; k++) begin
      full = p * longint'(k);
      if ((full >> 32) != 0) ovf = 1'b1;
      p = full & 64'h0000_0000_FFFF_FFFF;
    end
    res = p[31:0];
  endfunction

  task automatic idle();
    bus.MUX = 1'b0; bus.REG_LD = 1'b0; bus.CNT_LD = 1'b0;
    bus.CNT_EN = 1'b0; bus.DONE = 1'b0;
  endtask

  task automatic run(input int n, input bit change_n, input bit extra_ld);
    logic [31:0] exp_res;
    logic        exp_ovf;
    logic [63:0] p;
    int          cycles;
    ref_fact(n, exp_res, exp_ovf);
`ifndef FACT_DP_OVF_EN
    exp_ovf = 1'b0;
`endif
    bus.N = 4'(n); bus.CNT_LD = 1'b1; bus.REG_LD = 1'b1; bus.MUX = 1'b1;
    bus.CNT_EN = 1'b0; bus.DONE = 1'b0;
    tick();
    chk("load_product", 64'(bus.PRODUCT), 64'd1);
    chk("load_gt", 64'(bus.GT), 64'(n == 0));
    chk("load_ovf_clr", 64'(bus.OVF), 64'd0);
    bus.CNT_LD = 1'b0; bus.MUX = 1'b0; bus.REG_LD = 1'b1; bus.CNT_EN = 1'b1;
    cycles = 0;
    p = 64'd1;
    while (bus.GT !== 1'b1 && cycles < 20) begin
      if (change_n && cycles == 1) bus.N = 4'd9;
      tick();
      cycles++;
      p = (p * 64'(cycles)) & 64'h0000_0000_FFFF_FFFF;
      chk("step_product", 64'(bus.PRODUCT), p);
    end
    chk("gt_after_n_mults", 64'(cycles), 64'(n));
    chk("gt_high", 64'(bus.GT), 64'd1);
    if (extra_ld) begin
      tick();
      chk("extra_ld_product", 64'(bus.PRODUCT), 64'(exp_res));
    end
    chk("cnt_frozen", 64'(dut.cnt_s), 64'(n + 1));
    chk("final_product", 64'(bus.PRODUCT), 64'(exp_res));
    bus.REG_LD = 1'b0; bus.CNT_EN = 1'b0; bus.DONE = 1'b1;
    tick();
    chk("valid_pulse", 64'(bus.RESULT_VALID), 64'd1);
    chk("result", 64'(bus.RESULT), 64'(exp_res));
    chk("ovf", 64'(bus.OVF), 64'(exp_ovf));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("single_pulse", 64'(bus.RESULT_VALID), 64'd0);
    end
    bus.DONE = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    bus.N = 4'd0;
    idle();
    tick();
    tick();
    chk("rst_product", 64'(bus.PRODUCT), 64'd0);
    chk("rst_result", 64'(bus.RESULT), 64'd0);
    chk("rst_valid", 64'(bus.RESULT_VALID), 64'd0);
    chk("rst_gt", 64'(bus.GT), 64'd0);
    chk("rst_ovf", 64'(bus.OVF), 64'd0);
    RST = 1'b0;
    tick();

    run(5, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(12, 1'b0, 1'b0);
    run(13, 1'b0, 1'b0);
    run(5, 1'b1, 1'b1);

    // Reset during the third multiply cycle of N=7
    bus.N = 4'd7; bus.CNT_LD = 1'b1; bus.REG_LD = 1'b1; bus.MUX = 1'b1;
    tick();
    bus.CNT_LD = 1'b0; bus.MUX = 1'b0; bus.CNT_EN = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("midrst_product", 64'(bus.PRODUCT), 64'd0);
    chk("midrst_result", 64'(bus.RESULT), 64'd0);
    chk("midrst_valid", 64'(bus.RESULT_VALID), 64'd0);
    chk("midrst_gt", 64'(bus.GT), 64'd0);
    chk("midrst_ovf", 64'(bus.OVF), 64'd0);
    RST = 1'b0;
    idle();
    tick();
    chk("midrst_no_valid", 64'(bus.RESULT_VALID), 64'd0);
    run(4, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(15, 0));
      run(n, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
